// File: rtl/delay_line_ctrl_pkg.sv
// Shared types and default widths for the delay-line sequencer.
package delay_line_ctrl_pkg;

  localparam int unsigned A_WIDTH_DEF = 9;
  localparam int unsigned D_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PRIME = 2'b01,
    RUN   = 2'b10
  } state_t;

endpackage

// File: rtl/delay_addr_gen.sv
// Write pointer with clear/increment/wrap, plus the combinational read address
// (write pointer minus offset, modulo RAM depth).
module delay_addr_gen
  import delay_line_ctrl_pkg::*;
#(
  parameter int unsigned A_WIDTH = A_WIDTH_DEF,
  parameter int unsigned D_WIDTH = D_WIDTH_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               inc_i,
  input  logic [D_WIDTH-1:0] off_i,
  output logic [A_WIDTH-1:0] wptr_o,
  output logic [A_WIDTH-1:0] rd_addr_o
);

  logic [A_WIDTH-1:0] wptr_q, wptr_d;

  always_comb begin
    wptr_d = wptr_q;
    if (clr_i) begin
      wptr_d = '0;
    end else if (inc_i) begin
      wptr_d = wptr_q + A_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
    end
  end

  assign wptr_o    = wptr_q;
  assign rd_addr_o = wptr_q - A_WIDTH'(off_i);

endmodule

// File: rtl/delay_line_ctrl.sv
// Delay-line RAM sequencer: primes off_q samples, then writes and reads per tick.
// Optional re-prime counter enabled by DELAY_LINE_CTRL_STATS_EN.
module delay_line_ctrl
  import delay_line_ctrl_pkg::*;
#(
  parameter int unsigned A_WIDTH = A_WIDTH_DEF,
  parameter int unsigned D_WIDTH = D_WIDTH_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               sample_tick_i,
  input  logic [D_WIDTH-1:0] offset_i,
  output logic               wr_en_o,
  output logic               rd_en_o,
  output logic [A_WIDTH-1:0] wr_addr_o,
  output logic [A_WIDTH-1:0] rd_addr_o,
  output logic               out_valid_o,
  output logic               busy_o,
  output logic [1:0]         state_o
`ifdef DELAY_LINE_CTRL_STATS_EN
  ,
  output logic [15:0]        reprime_cnt_o
`endif
);

  if (D_WIDTH > A_WIDTH) begin : g_width_chk
    $error("delay_line_ctrl: D_WIDTH must not exceed A_WIDTH");
  end

  state_t             state_q, state_d;
  logic [D_WIDTH-1:0] off_q, off_d;
  logic [D_WIDTH-1:0] fill_q, fill_d, fill_inc;
  logic               wr_en_q, wr_en_d;
  logic               rd_en_q, rd_en_d;
  logic [A_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [A_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q;
  logic               ptr_clr, ptr_inc, arm, reprime;
  logic [A_WIDTH-1:0] wptr, rd_addr_calc;

  delay_addr_gen #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH)
  ) u_addr_gen (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (ptr_clr),
    .inc_i     (ptr_inc),
    .off_i     (off_q),
    .wptr_o    (wptr),
    .rd_addr_o (rd_addr_calc)
  );

  assign fill_inc = fill_q + D_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    fill_d      = fill_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    out_valid_d = rd_en_q;
    ptr_clr     = 1'b0;
    ptr_inc     = 1'b0;
    arm         = 1'b0;
    reprime     = 1'b0;
    if (stop_i) begin
      // Abort wins over everything, including a read already in flight.
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            arm     = 1'b1;
            off_d   = offset_i;
            fill_d  = '0;
            ptr_clr = 1'b1;
            state_d = (offset_i == '0) ? RUN : PRIME;
          end
        end
        PRIME, RUN: begin
          if (sample_tick_i) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wptr;
            ptr_inc   = 1'b1;
            if (offset_i != off_q) begin
              // New offset: this tick is the first sample of a fresh prime.
              reprime = 1'b1;
              off_d   = offset_i;
              fill_d  = D_WIDTH'(1);
              state_d = (offset_i <= D_WIDTH'(1)) ? RUN : PRIME;
            end else if (state_q == PRIME) begin
              fill_d = fill_inc;
              if (fill_inc == off_q) begin
                state_d = RUN;
              end
            end else begin
              rd_en_d   = 1'b1;
              rd_addr_d = rd_addr_calc;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      off_q       <= '0;
      fill_q      <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      fill_q      <= fill_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= out_valid_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign wr_en_o     = wr_en_q;
  assign rd_en_o     = rd_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign rd_addr_o   = rd_addr_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign state_o     = state_q;

`ifdef DELAY_LINE_CTRL_STATS_EN
  logic [15:0] reprime_cnt_q, reprime_cnt_d;

  always_comb begin
    reprime_cnt_d = reprime_cnt_q;
    if (arm) begin
      reprime_cnt_d = '0;
    end else if (reprime && (reprime_cnt_q != 16'hFFFF)) begin
      reprime_cnt_d = reprime_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reprime_cnt_q <= '0;
    end else begin
      reprime_cnt_q <= reprime_cnt_d;
    end
  end

  assign reprime_cnt_o = reprime_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = arm ^ reprime;
`endif

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl with a write/read scoreboard.
module tb_delay_line_ctrl;

  logic       clk;
  logic       rst_ni;
  logic       start_i, stop_i, sample_tick_i;
  logic [7:0] offset_i;
  logic       wr_en_o, rd_en_o, out_valid_o, busy_o;
  logic [8:0] wr_addr_o, rd_addr_o;
  logic [1:0] state_o;
`ifdef DELAY_LINE_CTRL_STATS_EN
  logic [15:0] reprime_cnt_o;
`endif

  delay_line_ctrl #(
    .A_WIDTH (9),
    .D_WIDTH (8)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .stop_i        (stop_i),
    .sample_tick_i (sample_tick_i),
    .offset_i      (offset_i),
    .wr_en_o       (wr_en_o),
    .rd_en_o       (rd_en_o),
    .wr_addr_o     (wr_addr_o),
    .rd_addr_o     (rd_addr_o),
    .out_valid_o   (out_valid_o),
    .busy_o        (busy_o),
    .state_o       (state_o)
`ifdef DELAY_LINE_CTRL_STATS_EN
    ,
    .reprime_cnt_o (reprime_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] wa;
    logic       rd;
    logic [8:0] ra;
  } item_t;

  item_t q[$];
  int    total = 0;
  int    bad   = 0;
  int    phase = 0;
  logic  v_next = 1'b0;
  logic  seen_wrap10 = 1'b0;

  // Reference model of the sequencer, advanced once per driven tick.
  int         m_state = 0;  // 0 idle, 1 prime, 2 run
  logic [8:0] m_wptr  = '0;
  logic [7:0] m_off   = '0;
  int         m_fill  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_tick();
    item_t it;
    if (m_state == 0) return;
    it.wa = m_wptr;
    it.rd = 1'b0;
    it.ra = '0;
    if (offset_i != m_off) begin
      m_off   = offset_i;
      m_fill  = 1;
      m_state = (m_fill >= int'(m_off)) ? 2 : 1;
    end else if (m_state == 1) begin
      m_fill++;
      if (m_fill == int'(m_off)) m_state = 2;
    end else begin
      it.rd = 1'b1;
      it.ra = m_wptr - {1'b0, m_off};
    end
    m_wptr = m_wptr + 9'd1;
    q.push_back(it);
  endtask

  task automatic tick_n(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      sample_tick_i = 1'b1;
      model_tick();
      @(posedge clk); #1;
      sample_tick_i = 1'b0;
      for (int j = 1; j < gap; j++) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic do_start(input logic [7:0] off);
    offset_i = off;
    start_i  = 1'b1;
    m_off    = off;
    m_fill   = 0;
    m_wptr   = '0;
    m_state  = (off == 8'd0) ? 2 : 1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic do_stop();
    stop_i = 1'b1;
    m_state = 0;
    @(posedge clk); #1;
    stop_i = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
  endtask

  // Scoreboard: every write pulse must match the next expected item.
  always @(negedge clk) begin
    item_t it;
    chk("out_valid", {31'd0, out_valid_o}, {31'd0, v_next & rst_ni});
    v_next = 1'b0;
    if (wr_en_o) begin
      if (q.size() == 0) begin
        chk("wr_unexpected", {31'd0, wr_en_o}, 32'd0);
      end else begin
        it = q.pop_front();
        chk("wr_addr", {23'd0, wr_addr_o}, {23'd0, it.wa});
        chk("rd_en", {31'd0, rd_en_o}, {31'd0, it.rd});
        if (it.rd) chk("rd_addr", {23'd0, rd_addr_o}, {23'd0, it.ra});
        v_next = it.rd;
      end
      if (phase == 3 && rd_en_o && wr_addr_o == 9'd10) begin
        seen_wrap10 = 1'b1;
        chk("wrap_rd_at_wa10", {23'd0, rd_addr_o}, 32'd267);
      end
    end else begin
      chk("rd_without_wr", {31'd0, rd_en_o}, 32'd0);
    end
    if (stop_i || !rst_ni) v_next = 1'b0;
  end

  initial begin
    rst_ni = 1'b0;
    start_i = 1'b0;
    stop_i = 1'b0;
    sample_tick_i = 1'b0;
    offset_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {30'd0, state_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en_o}, 32'd0);
    chk("rst_rd_en", {31'd0, rd_en_o}, 32'd0);
    chk("rst_wr_addr", {23'd0, wr_addr_o}, 32'd0);
    chk("rst_rd_addr", {23'd0, rd_addr_o}, 32'd0);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Ignored tick in IDLE.
    tick_n(2, 2);
    chk("idle_tick_state", {30'd0, state_o}, 32'd0);

    // Offset 3, slow ticks, then offset change 3 -> 5 while running.
    phase = 1;
    do_start(8'd3);
    chk("prime_state", {30'd0, state_o}, 32'd1);
    chk("prime_busy", {31'd0, busy_o}, 32'd1);
    tick_n(6, 4);
    drain();
    chk("run_state", {30'd0, state_o}, 32'd2);
    offset_i = 8'd5;
    tick_n(7, 4);
    drain();
`ifdef DELAY_LINE_CTRL_STATS_EN
    chk("reprime_cnt_one", {16'd0, reprime_cnt_o}, 32'd1);
`endif
    do_stop();
    chk("stop_state", {30'd0, state_o}, 32'd0);
    chk("stop_busy", {31'd0, busy_o}, 32'd0);

    // Offset 0: straight to RUN, continuous ticks.
    phase = 2;
    do_start(8'd0);
    chk("zero_off_state", {30'd0, state_o}, 32'd2);
    tick_n(10, 1);
    drain();
    do_stop();

    // Offset 255 across a pointer wrap.
    phase = 3;
    do_start(8'd255);
    tick_n(600, 1);
    drain();
    chk("wrap_seen", {31'd0, seen_wrap10}, 32'd1);
    do_stop();

    // Stop together with tick and start while a read is in flight.
    phase = 4;
    do_start(8'd3);
    tick_n(6, 1);
    stop_i = 1'b1;
    sample_tick_i = 1'b1;
    start_i = 1'b1;
    m_state = 0;
    @(posedge clk); #1;
    stop_i = 1'b0;
    sample_tick_i = 1'b0;
    start_i = 1'b0;
    chk("stopx_state", {30'd0, state_o}, 32'd0);
    chk("stopx_busy", {31'd0, busy_o}, 32'd0);
    chk("stopx_wr_en", {31'd0, wr_en_o}, 32'd0);
    chk("stopx_rd_en", {31'd0, rd_en_o}, 32'd0);
    chk("stopx_valid", {31'd0, out_valid_o}, 32'd0);
    drain();

    // Async reset mid-PRIME while a write pulse is high.
    phase = 5;
    do_start(8'd4);
    tick_n(2, 4);
    sample_tick_i = 1'b1;
    @(posedge clk); #1;
    sample_tick_i = 1'b0;
    chk("pre_rst_wr_en", {31'd0, wr_en_o}, 32'd1);
    chk("pre_rst_wr_addr", {23'd0, wr_addr_o}, 32'd2);
    #2;
    rst_ni = 1'b0;
    q.delete();
    #1;
    chk("async_wr_en", {31'd0, wr_en_o}, 32'd0);
    chk("async_wr_addr", {23'd0, wr_addr_o}, 32'd0);
    chk("async_busy", {31'd0, busy_o}, 32'd0);
    chk("async_state", {30'd0, state_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    m_state = 0;
    m_wptr = '0;
    m_off = '0;
`ifdef DELAY_LINE_CTRL_STATS_EN
    chk("reprime_cnt_rst", {16'd0, reprime_cnt_o}, 32'd0);
`endif
    do_start(8'd2);
    tick_n(4, 2);
    drain();
    do_stop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
